// File: rtl/pipe_alu.sv
// Handshaked ALU with a one-deep output register: logic/arith ops complete on the
// acceptance edge, MUL runs an LSB-first shift-add over WIDTH further edges.
module pipe_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero_flag,
  output logic             overflow_flag
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic {IDLE, MULT} state_t;

  state_t               state, state_nxt;
  logic                 accept, mul_last;
  logic [WIDTH:0]       alu_res;
  logic [2*WIDTH-1:0]   acc_nxt;

  logic                 vld_p1;
  logic [WIDTH-1:0]     res_p1;
  logic                 zf_p1, ovf_p1;
  logic [2*WIDTH-1:0]   acc_p1, mcand_p1;
  logic [WIDTH-1:0]     mplier_p1;
  logic [CNT_W-1:0]     cnt_p1;

  // Returns {overflow, result} for every single-cycle opcode; unknown codes give zero.
  function automatic logic [WIDTH:0] alu_op(input logic [3:0] op,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs, ys, sum, diff;
    logic                    add_ovf, sub_ovf;
    xs      = $signed(x);
    ys      = $signed(y);
    sum     = xs + ys;
    diff    = xs - ys;
    add_ovf = (xs[WIDTH-1] == ys[WIDTH-1]) && (sum[WIDTH-1] != xs[WIDTH-1]);
    sub_ovf = (xs[WIDTH-1] != ys[WIDTH-1]) && (diff[WIDTH-1] != xs[WIDTH-1]);
    case (op)
      OP_AND:  alu_op = {1'b0, x & y};
      OP_OR:   alu_op = {1'b0, x | y};
      OP_NOR:  alu_op = {1'b0, ~(x | y)};
      OP_ADD:  alu_op = {add_ovf, sum};
      OP_SUB:  alu_op = {sub_ovf, diff};
      // Sign of a-b is wrong exactly when the subtraction overflowed.
      OP_SLT:  alu_op = {1'b0, {(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_SLTU: alu_op = {1'b0, {(WIDTH-1){1'b0}}, x < y};
      default: alu_op = '0;
    endcase
  endfunction

  assign alu_res   = alu_op(ALUctl, a, b);
  assign in_ready  = (state == IDLE) && (!vld_p1 || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (state == MULT) && (cnt_p1 == CNT_W'(WIDTH - 1));
  assign acc_nxt   = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (ALUctl == OP_MUL)) state_nxt = MULT;
      MULT:    if (mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: result register and multiplier datapath ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      res_p1    <= '0;
      zf_p1     <= 1'b1;
      ovf_p1    <= 1'b0;
      acc_p1    <= '0;
      mcand_p1  <= '0;
      mplier_p1 <= '0;
      cnt_p1    <= '0;
    end else if (state == MULT) begin
      acc_p1    <= acc_nxt;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      cnt_p1    <= cnt_p1 + 1'b1;
      if (mul_last) begin
        res_p1 <= acc_nxt[WIDTH-1:0];
        zf_p1  <= ~|acc_nxt[WIDTH-1:0];
        ovf_p1 <= |acc_nxt[2*WIDTH-1:WIDTH];
        vld_p1 <= 1'b1;
      end
    end else if (accept) begin
      if (ALUctl == OP_MUL) begin
        acc_p1    <= '0;
        cnt_p1    <= '0;
        mcand_p1  <= {{WIDTH{1'b0}}, a};
        mplier_p1 <= b;
        vld_p1    <= 1'b0;
      end else begin
        res_p1 <= alu_res[WIDTH-1:0];
        ovf_p1 <= alu_res[WIDTH];
        zf_p1  <= ~|alu_res[WIDTH-1:0];
        vld_p1 <= 1'b1;
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign s             = res_p1;
  assign zero_flag     = zf_p1;
  assign overflow_flag = ovf_p1;

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: a 32-bit and an 8-bit instance, directed vectors
// with hand-computed results checked by per-instance output monitors.
module tb_pipe_alu;

  typedef struct packed {
    logic [31:0] s;
    logic        z;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv32 = 1'b0, ir32, ov32, rdy32 = 1'b1, z32, o32;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, s32;

  logic        iv8 = 1'b0, ir8, ov8, rdy8 = 1'b1, z8, o8;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, s8;

  exp_t q32[$];
  exp_t q8[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .ALUctl(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(rdy32), .s(s32),
    .zero_flag(z32), .overflow_flag(o32)
  );

  pipe_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .ALUctl(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(rdy8), .s(s8),
    .zero_flag(z8), .overflow_flag(o8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic issue(input bit sel, input logic [3:0] op, input logic [63:0] x,
                       input logic [63:0] y, input logic [31:0] es, input bit ez,
                       input bit eo, input bit push);
    bit   ok;
    exp_t e;
    if (sel) begin iv8 = 1'b1; op8 = op; a8 = x[7:0]; b8 = y[7:0]; end
    else     begin iv32 = 1'b1; op32 = op; a32 = x[31:0]; b32 = y[31:0]; end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel ? ir8 : ir32) begin ok = 1'b1; break; end
    end
    chk("accept_handshake", 64'(ok), 64'd1);
    e.s = es; e.z = ez; e.o = eo;
    if (ok && push) begin
      if (sel) q8.push_back(e);
      else     q32.push_back(e);
    end
    @(posedge clk); #1;
    if (sel) begin iv8 = 1'b0; op8 = 4'($urandom()); a8 = 8'($urandom()); b8 = 8'($urandom()); end
    else     begin iv32 = 1'b0; op32 = 4'($urandom()); a32 = $urandom(); b32 = $urandom(); end
  endtask

  // Multiply with busy-window checks; returns at posedge+1 after the result edge.
  task automatic mul(input bit sel, input logic [63:0] x, input logic [63:0] y,
                     input int n, input logic [31:0] es, input bit ez, input bit eo);
    issue(sel, 4'b0100, x, y, es, ez, eo, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 64'(sel ? ir8 : ir32), 64'd0);
      chk("mul_busy_out_valid", 64'(sel ? ov8 : ov32), 64'd0);
    end
    @(negedge clk);
    chk("mul_done_out_valid", 64'(sel ? ov8 : ov32), 64'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov32 && rdy32) begin
      if (q32.size() == 0) chk("w32_unexpected_result", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("w32_s", 64'(s32), 64'(e.s));
        chk("w32_zero_flag", 64'(z32), 64'(e.z));
        chk("w32_overflow_flag", 64'(o32), 64'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov8 && rdy8) begin
      if (q8.size() == 0) chk("w8_unexpected_result", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk("w8_s", 64'(s8), 64'(e.s[7:0]));
        chk("w8_zero_flag", 64'(z8), 64'(e.z));
        chk("w8_overflow_flag", 64'(o8), 64'(e.o));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov32), 64'd0);
    chk("reset_s", 64'(s32), 64'd0);
    chk("reset_zero_flag", 64'(z32), 64'd1);
    chk("reset_overflow_flag", 64'(o32), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(ir32), 64'd1);

    // Single-cycle ops, back-to-back.
    issue(0, 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 1);
    @(negedge clk);
    chk("add_latency_out_valid", 64'(ov32), 64'd1);
    @(posedge clk); #1;
    issue(0, 4'b0110, 32'd5, 32'd5, 32'd0, 1, 0, 1);
    issue(0, 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'd1, 0, 0, 1);
    issue(0, 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'd0, 1, 0, 1);
    issue(0, 4'b0111, 32'h8000_0000, 32'h1, 32'd1, 0, 0, 1);
    issue(0, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 1);
    issue(0, 4'b0001, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 0, 0, 1);
    issue(0, 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 1);
    issue(0, 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 1);
    issue(0, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 0, 1);

    // Iterative multiply.
    mul(0, 32'h0001_0000, 32'h0001_0000, 32, 32'd0, 1, 1);
    mul(0, 32'd1234, 32'd5678, 32, 32'd7006652, 0, 0);

    // Backpressure then replacement with no bubble.
    rdy32 = 1'b0;
    issue(0, 4'b0010, 32'd2, 32'd1, 32'd3, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_s", 64'(s32), 64'd3);
      chk("stall_out_valid", 64'(ov32), 64'd1);
      chk("stall_in_ready", 64'(ir32), 64'd0);
    end
    @(posedge clk); #1;
    rdy32 = 1'b1;
    issue(0, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 0, 0, 1);
    @(negedge clk);
    chk("no_bubble_out_valid", 64'(ov32), 64'd1);
    chk("no_bubble_s", 64'(s32), 64'hFF);
    @(posedge clk); #1;

    // Reset aborts a multiply in flight.
    issue(0, 4'b0100, 32'd1234, 32'd5678, 32'd0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(ov32), 64'd0);
    chk("abort_s", 64'(s32), 64'd0);
    chk("abort_zero_flag", 64'(z32), 64'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(ir32), 64'd1);
    issue(0, 4'b0010, 32'd1, 32'd1, 32'd2, 0, 0, 1);
    @(negedge clk);
    chk("post_abort_out_valid", 64'(ov32), 64'd1);
    chk("post_abort_s", 64'(s32), 64'd2);
    @(posedge clk); #1;

    // WIDTH=8 instance.
    mul(1, 8'd16, 8'd16, 8, 32'd0, 1, 1);
    issue(1, 4'b0010, 8'h7F, 8'h01, 32'h80, 0, 1, 1);
    issue(1, 4'b1111, 8'hAA, 8'h55, 32'd0, 1, 0, 1);
    mul(1, 8'd13, 8'd11, 8, 32'd143, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("w32_queue_drained", 64'(q32.size()), 64'd0);
    chk("w8_queue_drained", 64'(q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
